pll_lock_supervisor: RTL and testbench
======================================

Name: pll_lock_supervisor

Overview:
- Lock-side counterpart of the system PLL: consumes the PLL `locked` status and drives the PLL `rst` input.
- Runs on the 50 MHz reference clock, which is valid before lock.
- Sequences PLL reset, qualifies lock stability and gates the core's system reset.
- On loss of lock or lock timeout it re-resets the PLL and holds the core in reset until lock is stable again.

Parameters:
SYNC_STAGES, 2, synchronizer flops on pll_locked (≥2)
PLL_RST_CYCLES, 16, refclk cycles pll_rst is held high per reset pulse (≥1)
LOCK_STABLE, 1024, consecutive synchronized-lock cycles required before release (≥2)
LOCK_TIMEOUT, 1000000, refclk cycles to wait for lock before re-pulsing pll_rst (≥2)

Ports:
refclk  in  1  50 MHz reference clock; the only clock
rst  in  1  synchronous, active-high reset
pll_locked  in  1  PLL locked status; asynchronous to refclk
force_relock  in  1  single-cycle request to re-reset the PLL
pll_rst  out  1  reset to the PLL
sys_reset  out  1  core reset; high until lock is qualified
ready  out  1  high only in RUN (always equals ~sys_reset)
timeout_pulse  out  1  one-cycle pulse on lock timeout
lost_cnt  out  8  saturating count of lock losses while in RUN
state  out  2  debug: 0=PLL_RST, 1=WAIT_LOCK, 2=STABLE, 3=RUN

Behaviour:
Interface:
- One clock; reset is synchronous and active-high. The clock port is refclk and the reset port is rst. No other clock domain exists.

Reset (rst high at an edge):
- Sync chain → 0, state → PLL_RST, cnt → 0.
- pll_rst=1, sys_reset=1, ready=0, timeout_pulse=0, lost_cnt=0.
- rst dominates every other input.
- rst asserted mid-operation aborts the current state identically. lost_cnt is also cleared.

Synchronizer and counter:
- locked_s = pll_locked passed through SYNC_STAGES flops. The FSM uses only locked_s.
- Single shared counter, cnt, of width $clog2(max(PLL_RST_CYCLES, LOCK_STABLE, LOCK_TIMEOUT)) + 1. It is cleared on every state change.

State PLL_RST:
- pll_rst=1.
- cnt increments each cycle.
- At cnt==PLL_RST_CYCLES-1 → WAIT_LOCK.
- pll_rst is therefore high for exactly PLL_RST_CYCLES cycles after entry.

State WAIT_LOCK:
- pll_rst=0.
- If locked_s=1 → STABLE with cnt=1.
- Else if cnt==LOCK_TIMEOUT-1 → PLL_RST, with timeout_pulse=1 for one cycle.
- Else cnt increments.

State STABLE:
- If locked_s=0 → WAIT_LOCK (no timeout pulse, no lost_cnt change).
- Else if cnt==LOCK_STABLE-1 → RUN.
- Else cnt increments.
- Net effect: RUN is entered on the LOCK_STABLE-th consecutive edge sampling locked_s=1.

State RUN:
- sys_reset=0, ready=1.
- If locked_s=0 → PLL_RST, and lost_cnt increments (saturating at 255).
- Else if force_relock=1 → PLL_RST, lost_cnt unchanged.
- If both occur in the same cycle, count the loss.

force_relock outside RUN:
- In PLL_RST it is ignored.
- In WAIT_LOCK and STABLE it → PLL_RST with cnt cleared.

Output timing:
- All outputs are registered.
- sys_reset, ready and pll_rst change on the same edge as the state register, and are consistent with the new state.
- Latency from pll_locked falling (in RUN) to sys_reset=1 is SYNC_STAGES+1 edges.
- Glitches on pll_locked shorter than one cycle may be missed. This is acceptable.

Test Plan:
Parameters for all tests: SYNC_STAGES=2, PLL_RST_CYCLES=4, LOCK_STABLE=8, LOCK_TIMEOUT=32.
1. rst high for 3 cycles then low, pll_locked=0 → pll_rst=1 for exactly 4 cycles after release, then 0; state=1. Hold pll_locked=0 → timeout_pulse at cycle 32 of WAIT_LOCK, pll_rst high again for 4 cycles, and the sequence repeats.
2. pll_locked rises and stays high during WAIT_LOCK → state=2 two edges later. sys_reset falls and ready rises 8 edges after the first edge with locked_s=1. lost_cnt=0.
3. pll_locked drops for 3 cycles midway through STABLE → return to WAIT_LOCK. On re-lock the full 8-cycle qualification restarts. No timeout_pulse; lost_cnt unchanged.
4. In RUN, drop pll_locked → sys_reset=1 exactly 3 edges later, pll_rst=1 for 4 cycles, lost_cnt=1. Repeat 300 times → lost_cnt saturates at 255.
5. In RUN, pulse force_relock for 1 cycle → PLL_RST next edge, lost_cnt unchanged, then normal relock. Assert force_relock in the same cycle locked_s falls → lost_cnt increments.
6. Assert rst while in RUN with lost_cnt=5 → next edge: state=0, pll_rst=1, sys_reset=1, ready=0, lost_cnt=0.

Source files
------------

// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock stability on the
// reference clock and holds the core in reset until lock is trusted.
module pll_lock_supervisor #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_STABLE    = 1024,
  parameter int LOCK_TIMEOUT   = 1000000
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       force_relock,
  output logic       pll_rst,
  output logic       sys_reset,
  output logic       ready,
  output logic       timeout_pulse,
  output logic [7:0] lost_cnt,
  output logic [1:0] state
);

  localparam int MAX_AB  = (PLL_RST_CYCLES > LOCK_STABLE) ? PLL_RST_CYCLES : LOCK_STABLE;
  localparam int MAX_CNT = (MAX_AB > LOCK_TIMEOUT) ? MAX_AB : LOCK_TIMEOUT;
  localparam int CW      = $clog2(MAX_CNT) + 1;

  localparam logic [CW-1:0] CNT_ONE     = CW'(1);
  localparam logic [CW-1:0] RST_LAST    = CW'(PLL_RST_CYCLES - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_PLL_RST   = 2'd0,
    S_WAIT_LOCK = 2'd1,
    S_STABLE    = 2'd2,
    S_RUN       = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;
  state_t                 cur_state, nxt_state;
  logic [CW-1:0]          cnt, cnt_nxt;
  logic                   tp_nxt;
  logic [7:0]             lost_nxt;

  // pll_locked is asynchronous to refclk; only the last stage feeds the FSM.
  // NOTE: sequential state uses <= so every flop samples pre-edge values, which
  // is what makes the synchronizer chain shift instead of collapsing.
  always_ff @(posedge refclk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  // NOTE: every variable gets a default before the case so no path leaves one
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    nxt_state = cur_state;
    cnt_nxt   = cnt + CNT_ONE;
    tp_nxt    = 1'b0;
    lost_nxt  = lost_cnt;
    unique case (cur_state)
      S_PLL_RST: begin
        if (cnt == RST_LAST) nxt_state = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        if (force_relock) nxt_state = S_PLL_RST;
        else if (locked_s) nxt_state = S_STABLE;
        else if (cnt == TO_LAST) begin
          nxt_state = S_PLL_RST;
          tp_nxt    = 1'b1;
        end
      end
      S_STABLE: begin
        if (force_relock) nxt_state = S_PLL_RST;
        else if (!locked_s) nxt_state = S_WAIT_LOCK;
        else if (cnt == STABLE_LAST) nxt_state = S_RUN;
      end
      S_RUN: begin
        cnt_nxt = cnt;
        if (!locked_s) begin
          nxt_state = S_PLL_RST;
          if (lost_cnt != 8'hFF) lost_nxt = lost_cnt + 8'd1;
        end else if (force_relock) begin
          nxt_state = S_PLL_RST;
        end
      end
      default: nxt_state = S_PLL_RST;
    endcase
    // STABLE is entered on the first locked sample, so that sample already counts.
    if (nxt_state != cur_state) cnt_nxt = (nxt_state == S_STABLE) ? CNT_ONE : '0;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      cur_state     <= S_PLL_RST;
      cnt           <= '0;
      pll_rst       <= 1'b1;
      sys_reset     <= 1'b1;
      ready         <= 1'b0;
      timeout_pulse <= 1'b0;
      lost_cnt      <= 8'd0;
    end else begin
      cur_state     <= nxt_state;
      cnt           <= cnt_nxt;
      pll_rst       <= (nxt_state == S_PLL_RST);
      sys_reset     <= (nxt_state != S_RUN);
      ready         <= (nxt_state == S_RUN);
      timeout_pulse <= tp_nxt;
      lost_cnt      <= lost_nxt;
    end
  end

  assign state = cur_state;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: each step queues the expected
// output vector, advances one refclk edge, then pops and compares.
module tb_pll_lock_supervisor;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       force_relock;
  logic       pll_rst;
  logic       sys_reset;
  logic       ready;
  logic       timeout_pulse;
  logic [7:0] lost_cnt;
  logic [1:0] state;

  int         n_total = 0;
  int         n_bad   = 0;
  logic [7:0] lc_exp;

  typedef struct {
    string      tag;
    logic [13:0] val;
  } exp_t;

  exp_t sb_q[$];

  pll_lock_supervisor #(
    .SYNC_STAGES   (2),
    .PLL_RST_CYCLES(4),
    .LOCK_STABLE   (8),
    .LOCK_TIMEOUT  (32)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .force_relock (force_relock),
    .pll_rst      (pll_rst),
    .sys_reset    (sys_reset),
    .ready        (ready),
    .timeout_pulse(timeout_pulse),
    .lost_cnt     (lost_cnt),
    .state        (state)
  );

  always #10 refclk = ~refclk;

  // {state, pll_rst, sys_reset, ready, timeout_pulse, lost_cnt}
  function automatic logic [13:0] mk(input logic [1:0] st, input logic tp, input logic [7:0] lc);
    logic pr, sr, rd;
    pr = (st == 2'd0);
    sr = (st != 2'd3);
    rd = (st == 2'd3);
    return {st, pr, sr, rd, tp, lc};
  endfunction

  function automatic logic [13:0] obs();
    return {state, pll_rst, sys_reset, ready, timeout_pulse, lost_cnt};
  endfunction

  task automatic check(input string tag, input logic [13:0] act, input logic [13:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d pr=%b sr=%b rd=%b tp=%b lc=%0d want st=%0d pr=%b sr=%b rd=%b tp=%b lc=%0d",
               tag, act[13:12], act[11], act[10], act[9], act[8], act[7:0],
               exp[13:12], exp[11], exp[10], exp[9], exp[8], exp[7:0]);
    end
  endtask

  task automatic step(input string tag, input logic [1:0] st, input logic tp);
    exp_t e;
    e.tag = tag;
    e.val = mk(st, tp, lc_exp);
    sb_q.push_back(e);
    @(posedge refclk);
    #1;
    e = sb_q.pop_front();
    check(e.tag, obs(), e.val);
  endtask

  task automatic steps(input string tag, input int n, input logic [1:0] st);
    for (int i = 0; i < n; i++) step(tag, st, 1'b0);
  endtask

  // Fresh PLL_RST entry already observed: three more PLL_RST edges, then WAIT_LOCK.
  task automatic pll_rst_phase(input string tag);
    steps(tag, 3, 2'd0);
    step(tag, 2'd1, 1'b0);
  endtask

  // pll_locked just raised while in WAIT_LOCK with locked_s low.
  task automatic qualify(input string tag);
    steps(tag, 2, 2'd1);
    steps(tag, 7, 2'd2);
    step(tag, 2'd3, 1'b0);
  endtask

  // PLL_RST entry observed with pll_locked already high long enough.
  task automatic relock_high(input string tag);
    pll_rst_phase(tag);
    steps(tag, 7, 2'd2);
    step(tag, 2'd3, 1'b0);
  endtask

  task automatic lose_lock(input string tag);
    pll_locked = 1'b0;
    steps(tag, 2, 2'd3);
    if (lc_exp != 8'hFF) lc_exp++;
    step(tag, 2'd0, 1'b0);
    pll_rst_phase(tag);
    pll_locked = 1'b1;
    qualify(tag);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    pll_locked   = 1'b0;
    force_relock = 1'b0;
    lc_exp       = 8'd0;

    // Reset, then two full lock-timeout cycles.
    steps("reset", 3, 2'd0);
    rst = 1'b0;
    pll_rst_phase("t1_rst");
    steps("t1_wait", 31, 2'd1);
    step("t1_timeout", 2'd0, 1'b1);
    pll_rst_phase("t1_rst2");
    steps("t1_wait2", 31, 2'd1);
    step("t1_timeout2", 2'd0, 1'b1);
    pll_rst_phase("t1_rst3");

    // Lock, dropout midway through STABLE, full re-qualification.
    pll_locked = 1'b1;
    steps("t3_sync", 2, 2'd1);
    steps("t3_stable", 3, 2'd2);
    pll_locked = 1'b0;
    steps("t3_drop", 2, 2'd2);
    step("t3_back", 2'd1, 1'b0);
    pll_locked = 1'b1;
    qualify("t3_requal");

    // force_relock from RUN, ignored inside PLL_RST.
    force_relock = 1'b1;
    step("t5_force", 2'd0, 1'b0);
    step("t5_ignored", 2'd0, 1'b0);
    force_relock = 1'b0;
    steps("t5_rst", 2, 2'd0);
    step("t5_wait", 2'd1, 1'b0);
    steps("t5_stable", 7, 2'd2);
    step("t5_run", 2'd3, 1'b0);

    // force_relock on the same edge locked_s falls counts as a loss.
    pll_locked = 1'b0;
    steps("t5_both", 2, 2'd3);
    force_relock = 1'b1;
    lc_exp = 8'd1;
    step("t5_both_hit", 2'd0, 1'b0);
    force_relock = 1'b0;
    pll_rst_phase("t5_both_rst");
    pll_locked = 1'b1;
    qualify("t5_both_up");

    // force_relock while in STABLE.
    force_relock = 1'b1;
    step("t5_stb_go", 2'd0, 1'b0);
    force_relock = 1'b0;
    pll_rst_phase("t5_stb_rst");
    steps("t5_stb", 2, 2'd2);
    force_relock = 1'b1;
    step("t5_stb_force", 2'd0, 1'b0);
    force_relock = 1'b0;
    relock_high("t5_stb_up");

    // Repeated lock losses saturate lost_cnt.
    for (int i = 0; i < 300; i++) lose_lock("t4_loss");

    // Reset clears a saturated counter; build to 5 losses and reset from RUN.
    rst    = 1'b1;
    lc_exp = 8'd0;
    step("t6_rst_sat", 2'd0, 1'b0);
    rst = 1'b0;
    relock_high("t6_up");
    for (int i = 0; i < 5; i++) lose_lock("t6_loss");
    rst    = 1'b1;
    lc_exp = 8'd0;
    step("t6_rst_run", 2'd0, 1'b0);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
